hs_io_master: RTL and testbench

Initiator for the MicroBlaze-MCS-style IO bus that fronts the SATA DMA/control register space (dma0–3 at offsets 0x000–0x3FF, ctrl at 0x800). It accepts single register requests on a valid/ready request channel, drives one IO bus transaction per request, and waits for `IO_Ready` under a timeout. It returns read data or an error on a valid/ready response channel. It lets a host-side agent, such as the debug or PCIe bridge, reach the same registers the MCS firmware uses.

---
 rtl/hs_io_pkg.sv | 20 ++
 rtl/hs_io_master_if.sv | 42 ++++
 rtl/hs_io_master.sv | 148 ++++++++++++++
 tb/tb_hs_io_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_io_pkg.sv
// Shared types and constants for the host-side IO bus initiator that reaches
// the SATA DMA/control register space.
package hs_io_pkg;

  typedef enum logic [1:0] {
    HS_IDLE   = 2'd0,
    HS_STROBE = 2'd1,
    HS_WAIT   = 2'd2,
    HS_RESP   = 2'd3
  } hs_state_e;

  localparam logic [31:0] DMA0_BASE = 32'h0000_0000;
  localparam logic [31:0] DMA1_BASE = 32'h0000_0100;
  localparam logic [31:0] DMA2_BASE = 32'h0000_0200;
  localparam logic [31:0] DMA3_BASE = 32'h0000_0300;
  localparam logic [31:0] CTRL_BASE = 32'h0000_0800;

  localparam logic [31:0] HS_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/hs_io_master_if.sv
// Request/response channels plus the MCS-style IO bus, bundled for hs_io_master.
// The master modport is the initiator's view; slave is the host/responder view.
interface hs_io_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        IO_Addr_Strobe;
  logic        IO_Read_Strobe;
  logic        IO_Write_Strobe;
  logic [31:0] IO_Address;
  logic [3:0]  IO_Byte_Enable;
  logic [31:0] IO_Write_Data;
  logic [31:0] IO_Read_Data;
  logic        IO_Ready;

  modport master (
    input  req_valid, req_write, req_addr, req_be, req_wdata, rsp_ready,
           IO_Read_Data, IO_Ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe,
           IO_Address, IO_Byte_Enable, IO_Write_Data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_be, req_wdata, rsp_ready,
           IO_Read_Data, IO_Ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe,
           IO_Address, IO_Byte_Enable, IO_Write_Data
  );

endinterface

// File: rtl/hs_io_master.sv
// Single-outstanding IO bus initiator: one strobe per request, waits for
// IO_Ready under a timeout and returns data or an error response.
module hs_io_master
  import hs_io_pkg::*;
#(
  parameter int unsigned C_TIMEOUT  = 255,
  parameter logic [31:0] C_ERR_DATA = HS_ERR_DATA_DEFAULT
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  hs_io_master_if.master bus,
  output logic [7:0]     tmo_count
);

  localparam logic [1:0] IDLE   = HS_IDLE;
  localparam logic [1:0] STROBE = HS_STROBE;
  localparam logic [1:0] WAIT   = HS_WAIT;
  localparam logic [1:0] RESP   = HS_RESP;

  localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        write_q, write_d;
  logic        addr_stb_q, addr_stb_d;
  logic        rd_stb_q, rd_stb_d;
  logic        wr_stb_q, wr_stb_d;
  logic [31:0] io_addr_q, io_addr_d;
  logic [3:0]  io_be_q, io_be_d;
  logic [31:0] io_wdata_q, io_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  tmo_count_q, tmo_count_d;

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    write_d     = write_q;
    addr_stb_d  = 1'b0;
    rd_stb_d    = 1'b0;
    wr_stb_d    = 1'b0;
    io_addr_d   = io_addr_q;
    io_be_d     = io_be_q;
    io_wdata_d  = io_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    tmo_count_d = tmo_count_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          write_d     = bus.req_write;
          io_addr_d   = bus.req_addr;
          io_be_d     = bus.req_be;
          io_wdata_d  = bus.req_wdata;
          addr_stb_d  = 1'b1;
          wr_stb_d    = bus.req_write;
          rd_stb_d    = !bus.req_write;
          req_ready_d = 1'b0;
          state_d     = STROBE;
        end
      end

      // STROBE and WAIT share completion; IO_Ready is tested first so it
      // beats a timeout landing in the same cycle.
      STROBE, WAIT: begin
        cnt_d = (state_q == STROBE) ? 16'd0 : cnt_q + 16'd1;
        if (bus.IO_Ready) begin
          rsp_rdata_d = write_q ? 32'd0 : bus.IO_Read_Data;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (state_q == WAIT && cnt_q == TMO_LAST) begin
          rsp_rdata_d = write_q ? 32'd0 : C_ERR_DATA;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          if (tmo_count_q != 8'hFF) begin
            tmo_count_d = tmo_count_q + 8'd1;
          end
          state_d     = RESP;
        end else begin
          state_d = WAIT;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      write_q     <= 1'b0;
      addr_stb_q  <= 1'b0;
      rd_stb_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      io_addr_q   <= 32'd0;
      io_be_q     <= 4'd0;
      io_wdata_q  <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= 16'd0;
      tmo_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      write_q     <= write_d;
      addr_stb_q  <= addr_stb_d;
      rd_stb_q    <= rd_stb_d;
      wr_stb_q    <= wr_stb_d;
      io_addr_q   <= io_addr_d;
      io_be_q     <= io_be_d;
      io_wdata_q  <= io_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      tmo_count_q <= tmo_count_d;
    end
  end

  assign bus.req_ready       = req_ready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.rsp_err         = rsp_err_q;
  assign bus.IO_Addr_Strobe  = addr_stb_q;
  assign bus.IO_Read_Strobe  = rd_stb_q;
  assign bus.IO_Write_Strobe = wr_stb_q;
  assign bus.IO_Address      = io_addr_q;
  assign bus.IO_Byte_Enable  = io_be_q;
  assign bus.IO_Write_Data   = io_wdata_q;
  assign tmo_count           = tmo_count_q;

endmodule

// File: tb/tb_hs_io_master.sv
// Self-checking bench for hs_io_master: directed scenarios plus randomized
// back-to-back traffic, checked against a cycle-count model of the bus rules.
module tb_hs_io_master;
  import hs_io_pkg::*;

  localparam int unsigned TMO   = 8;
  localparam int          LIMIT = 100;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [7:0] tmo_count;

  hs_io_master_if bus ();

  hs_io_master #(
    .C_TIMEOUT  (TMO),
    .C_ERR_DATA (HS_ERR_DATA_DEFAULT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .tmo_count (tmo_count)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int passed = 0;
  int exp_tmo = 0;

  // Observations recorded by run_txn; each scenario compares them itself.
  bit          obs_tmo, obs_accept_ready, obs_stable, obs_held, obs_req_low;
  bit          obs_ready_after, obs_valid_after, obs_wr_stb, obs_rd_stb;
  int          obs_strobe_cnt, obs_strobe_t, obs_rsp_off, obs_rsp_cycles;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_be;
  logic        obs_err;

  // Model: completion when IO_Ready lands in the strobe cycle or any of the
  // TMO wait cycles after it, otherwise a timeout TMO+1 cycles after strobe.
  int          exp_off;
  logic        exp_err;
  logic [31:0] exp_rdata;

  function automatic void model(input logic wr, input int rdy_dly, input logic [31:0] rd_val);
    if (rdy_dly >= 0 && rdy_dly <= int'(TMO)) begin
      exp_off   = rdy_dly + 1;
      exp_err   = 1'b0;
      exp_rdata = wr ? 32'd0 : rd_val;
    end else begin
      exp_off   = int'(TMO) + 1;
      exp_err   = 1'b1;
      exp_rdata = wr ? 32'd0 : HS_ERR_DATA_DEFAULT;
      if (exp_tmo < 255) exp_tmo = exp_tmo + 1;
    end
  endfunction

  // Called #1 after a clock edge; issues the request in the current cycle and
  // returns in the cycle after the response handshake.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input int rdy_dly, input logic [31:0] rd_val,
                         input int hold, input bit late);
    int  strobe_t = -1;
    int  rsp_t    = -1;
    int  rsp_seen = 0;
    bit  hs_done  = 0;
    bit  done     = 0;
    obs_tmo = 0; obs_stable = 1; obs_held = 1; obs_req_low = 1;
    obs_strobe_cnt = 0; obs_strobe_t = -1; obs_rsp_off = -1;
    obs_ready_after = 0; obs_valid_after = 1;
    obs_accept_ready = bus.req_ready;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_be = be; bus.req_wdata = wdata;
    for (int t = 1; t <= LIMIT && !done; t++) begin
      @(posedge sys_clk); #1;
      bus.req_valid = 1'b0;
      if (hs_done) begin
        obs_ready_after = bus.req_ready;
        obs_valid_after = bus.rsp_valid;
        done = 1;
      end else begin
        if (bus.req_ready) obs_req_low = 0;
        if (bus.IO_Addr_Strobe) begin
          obs_strobe_cnt++;
          if (strobe_t < 0) begin
            strobe_t = t; obs_strobe_t = t;
            obs_addr = bus.IO_Address; obs_be = bus.IO_Byte_Enable; obs_wdata = bus.IO_Write_Data;
            obs_wr_stb = bus.IO_Write_Strobe; obs_rd_stb = bus.IO_Read_Strobe;
          end
        end else if (strobe_t >= 0 && rsp_t < 0) begin
          if (bus.IO_Address !== obs_addr || bus.IO_Byte_Enable !== obs_be ||
              bus.IO_Write_Data !== obs_wdata || bus.IO_Read_Strobe || bus.IO_Write_Strobe)
            obs_stable = 0;
        end
        if (bus.rsp_valid) begin
          if (rsp_t < 0) begin
            rsp_t = t; obs_rsp_off = t - strobe_t;
            obs_rdata = bus.rsp_rdata; obs_err = bus.rsp_err;
          end else if (bus.rsp_rdata !== obs_rdata || bus.rsp_err !== obs_err) begin
            obs_held = 0;
          end
          rsp_seen++;
        end
        bus.IO_Ready = (strobe_t >= 0 && rdy_dly >= 0 && t == strobe_t + rdy_dly) ||
                       (late && rsp_seen == 1);
        bus.IO_Read_Data = (rsp_seen >= 1) ? ~rd_val : rd_val;
        bus.rsp_ready = (rsp_seen > hold);
        if (bus.rsp_valid && bus.rsp_ready) hs_done = 1;
      end
    end
    obs_rsp_cycles = rsp_seen;
    bus.IO_Ready = 1'b0; bus.rsp_ready = 1'b0; bus.req_valid = 1'b0;
    if (!done) obs_tmo = 1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; #3;
    checks++; if (bus.req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready: got %0b expected 1", bus.req_ready); else passed++;
    checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== 34'd0) $display("[TB] FAIL reset_rsp: got %h expected 0", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}); else passed++;
    checks++; if ({bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe, bus.IO_Address, bus.IO_Byte_Enable, bus.IO_Write_Data} !== 71'd0) $display("[TB] FAIL reset_io: got %h expected 0", bus.IO_Address); else passed++;
    checks++; if (tmo_count !== 8'd0) $display("[TB] FAIL reset_tmo_count: got %0d expected 0", tmo_count); else passed++;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_write();
    model(1'b1, 2, 32'h0);
    run_txn(1'b1, CTRL_BASE + 32'h10, 4'hF, 32'h0000_0123, 2, $urandom, 0, 0);
    checks++; if (obs_tmo) $display("[TB] FAIL write_bound: got stuck expected handshake"); else passed++;
    checks++; if (obs_accept_ready !== 1'b1) $display("[TB] FAIL write_accept_ready: got %0b expected 1", obs_accept_ready); else passed++;
    checks++; if (obs_strobe_cnt != 1 || obs_strobe_t != 1) $display("[TB] FAIL write_strobe: got cnt %0d at %0d expected 1 at 1", obs_strobe_cnt, obs_strobe_t); else passed++;
    checks++; if ({obs_wr_stb, obs_rd_stb} !== 2'b10) $display("[TB] FAIL write_strobe_kind: got %b expected 10", {obs_wr_stb, obs_rd_stb}); else passed++;
    checks++; if (obs_addr !== 32'h0000_0810 || obs_be !== 4'hF || obs_wdata !== 32'h0000_0123) $display("[TB] FAIL write_bus: got %h %h %h expected 00000810 f 00000123", obs_addr, obs_be, obs_wdata); else passed++;
    checks++; if (obs_rsp_off != exp_off) $display("[TB] FAIL write_latency: got %0d expected %0d", obs_rsp_off, exp_off); else passed++;
    checks++; if (obs_err !== exp_err || obs_rdata !== exp_rdata) $display("[TB] FAIL write_rsp: got %0b %h expected %0b %h", obs_err, obs_rdata, exp_err, exp_rdata); else passed++;
    checks++; if (!obs_stable) $display("[TB] FAIL write_stable: got changing bus expected stable"); else passed++;
  endtask

  task automatic test_read();
    model(1'b0, 2, 32'hCAFE_F00D);
    run_txn(1'b0, DMA1_BASE, 4'hF, $urandom, 2, 32'hCAFE_F00D, 0, 0);
    checks++; if (obs_tmo) $display("[TB] FAIL read_bound: got stuck expected handshake"); else passed++;
    checks++; if ({obs_wr_stb, obs_rd_stb} !== 2'b01 || obs_addr !== 32'h100) $display("[TB] FAIL read_strobe: got %b %h expected 01 00000100", {obs_wr_stb, obs_rd_stb}, obs_addr); else passed++;
    checks++; if (obs_rsp_off != exp_off) $display("[TB] FAIL read_latency: got %0d expected %0d", obs_rsp_off, exp_off); else passed++;
    checks++; if (obs_err !== exp_err || obs_rdata !== exp_rdata) $display("[TB] FAIL read_rsp: got %0b %h expected %0b %h", obs_err, obs_rdata, exp_err, exp_rdata); else passed++;
  endtask

  task automatic test_timeout();
    model(1'b0, -1, 32'h0);
    run_txn(1'b0, CTRL_BASE, 4'h3, $urandom, -1, $urandom, 2, 1);
    checks++; if (obs_tmo) $display("[TB] FAIL tmo_bound: got stuck expected handshake"); else passed++;
    checks++; if (obs_rsp_off != exp_off) $display("[TB] FAIL tmo_latency: got %0d expected %0d", obs_rsp_off, exp_off); else passed++;
    checks++; if (obs_err !== exp_err || obs_rdata !== exp_rdata) $display("[TB] FAIL tmo_rsp: got %0b %h expected %0b %h", obs_err, obs_rdata, exp_err, exp_rdata); else passed++;
    checks++; if (int'(tmo_count) != exp_tmo) $display("[TB] FAIL tmo_count: got %0d expected %0d", tmo_count, exp_tmo); else passed++;
    checks++; if (!obs_held) $display("[TB] FAIL tmo_late_ready: got altered response expected held"); else passed++;
    model(1'b1, -1, 32'h0);
    run_txn(1'b1, DMA0_BASE, 4'hF, $urandom, -1, $urandom, 0, 0);
    checks++; if (obs_err !== exp_err || obs_rdata !== exp_rdata) $display("[TB] FAIL tmo_write_rsp: got %0b %h expected %0b %h", obs_err, obs_rdata, exp_err, exp_rdata); else passed++;
    checks++; if (int'(tmo_count) != exp_tmo) $display("[TB] FAIL tmo_count_2: got %0d expected %0d", tmo_count, exp_tmo); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d = $urandom;
    model(1'b0, 3, d);
    run_txn(1'b0, DMA2_BASE + 32'h8, 4'hF, $urandom, 3, d, 10, 0);
    checks++; if (obs_tmo) $display("[TB] FAIL bp_bound: got stuck expected handshake"); else passed++;
    checks++; if (obs_rsp_cycles != 11 || !obs_held) $display("[TB] FAIL bp_hold: got %0d cycles held=%0b expected 11 held=1", obs_rsp_cycles, obs_held); else passed++;
    checks++; if (obs_rdata !== exp_rdata) $display("[TB] FAIL bp_data: got %h expected %h", obs_rdata, exp_rdata); else passed++;
    checks++; if (!obs_req_low || obs_strobe_cnt != 1) $display("[TB] FAIL bp_single: got req_low=%0b strobes=%0d expected 1 1", obs_req_low, obs_strobe_cnt); else passed++;
    checks++; if (obs_ready_after !== 1'b1 || obs_valid_after !== 1'b0) $display("[TB] FAIL bp_release: got ready=%0b valid=%0b expected 1 0", obs_ready_after, obs_valid_after); else passed++;
  endtask

  task automatic test_same_cycle();
    logic [31:0] d = $urandom;
    model(1'b0, 0, d);
    run_txn(1'b0, DMA3_BASE + 32'h4, 4'hF, $urandom, 0, d, 0, 0);
    checks++; if (obs_rsp_off != exp_off || obs_rdata !== exp_rdata || obs_err !== exp_err) $display("[TB] FAIL same_cycle: got %0d %h %0b expected %0d %h %0b", obs_rsp_off, obs_rdata, obs_err, exp_off, exp_rdata, exp_err); else passed++;
    model(1'b0, int'(TMO), d);
    run_txn(1'b0, DMA0_BASE + 32'h20, 4'hF, $urandom, int'(TMO), d, 0, 0);
    checks++; if (obs_rsp_off != exp_off || obs_rdata !== exp_rdata || obs_err !== exp_err) $display("[TB] FAIL ready_vs_tmo: got %0d %h %0b expected %0d %h %0b", obs_rsp_off, obs_rdata, obs_err, exp_off, exp_rdata, exp_err); else passed++;
    checks++; if (int'(tmo_count) != exp_tmo) $display("[TB] FAIL ready_vs_tmo_count: got %0d expected %0d", tmo_count, exp_tmo); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] regions [5];
    regions = '{DMA0_BASE, DMA1_BASE, DMA2_BASE, DMA3_BASE, CTRL_BASE};
    for (int n = 0; n < 25; n++) begin
      logic        wr   = 1'($urandom);
      logic [31:0] addr = regions[$urandom_range(0, 4)] + ($urandom & 32'hFC);
      logic [3:0]  be   = 4'($urandom);
      logic [31:0] wd   = $urandom;
      logic [31:0] rd   = $urandom;
      int          dly  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TMO + 2));
      int          hold = int'($urandom_range(0, 3));
      bit          late = 1'($urandom);
      model(wr, dly, rd);
      run_txn(wr, addr, be, wd, dly, rd, hold, late);
      checks++; if (obs_tmo || obs_accept_ready !== 1'b1) $display("[TB] FAIL b2b_flow[%0d]: got stuck=%0b ready=%0b expected 0 1", n, obs_tmo, obs_accept_ready); else passed++;
      checks++; if (obs_addr !== addr || obs_be !== be || obs_wdata !== wd || obs_strobe_cnt != 1) $display("[TB] FAIL b2b_bus[%0d]: got %h %h %h x%0d expected %h %h %h x1", n, obs_addr, obs_be, obs_wdata, obs_strobe_cnt, addr, be, wd); else passed++;
      checks++; if (obs_rsp_off != exp_off || obs_err !== exp_err || obs_rdata !== exp_rdata) $display("[TB] FAIL b2b_rsp[%0d]: got %0d %0b %h expected %0d %0b %h", n, obs_rsp_off, obs_err, obs_rdata, exp_off, exp_err, exp_rdata); else passed++;
      checks++; if (!obs_held || !obs_stable || int'(tmo_count) != exp_tmo) $display("[TB] FAIL b2b_state[%0d]: got held=%0b stable=%0b tmo=%0d expected 1 1 %0d", n, obs_held, obs_stable, tmo_count, exp_tmo); else passed++;
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 260; n++) begin
      model(1'($urandom), -1, 32'h0);
      run_txn(1'($urandom), DMA2_BASE, 4'hF, $urandom, -1, $urandom, 0, 0);
    end
    checks++; if (int'(tmo_count) != exp_tmo || tmo_count !== 8'd255) $display("[TB] FAIL tmo_saturate: got %0d expected %0d", tmo_count, exp_tmo); else passed++;
  endtask

  task automatic test_reset_mid_txn();
    bit quiet = 1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = DMA2_BASE + 32'h10;
    bus.req_be = 4'hF; bus.req_wdata = 32'h5555_AAAA;
    @(posedge sys_clk); #1 bus.req_valid = 1'b0;
    repeat (3) @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    exp_tmo = 0;
    checks++; if ({bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe, bus.IO_Address, bus.IO_Byte_Enable, bus.IO_Write_Data} !== 71'd0) $display("[TB] FAIL midrst_io: got addr %h expected 0", bus.IO_Address); else passed++;
    checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== 34'd0 || tmo_count !== 8'd0) $display("[TB] FAIL midrst_rsp: got %0b %0d expected 0 0", bus.rsp_valid, tmo_count); else passed++;
    checks++; if (bus.req_ready !== 1'b1) $display("[TB] FAIL midrst_req_ready: got %0b expected 1", bus.req_ready); else passed++;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    bus.IO_Ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge sys_clk); #1;
      bus.IO_Ready = 1'b0;
      if (bus.rsp_valid || bus.IO_Addr_Strobe) quiet = 0;
    end
    checks++; if (!quiet) $display("[TB] FAIL midrst_dropped: got activity expected none"); else passed++;
    model(1'b0, 2, 32'h1234_5678);
    run_txn(1'b0, DMA3_BASE, 4'hF, $urandom, 2, 32'h1234_5678, 0, 0);
    checks++; if (obs_tmo || obs_addr !== 32'h300 || obs_rsp_off != exp_off || obs_rdata !== exp_rdata || obs_err !== exp_err) $display("[TB] FAIL midrst_recover: got %h %0d %h %0b expected 00000300 %0d %h %0b", obs_addr, obs_rsp_off, obs_rdata, obs_err, exp_off, exp_rdata, exp_err); else passed++;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'd0;
    bus.req_be = 4'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b0;
    bus.IO_Read_Data = 32'd0; bus.IO_Ready = 1'b0;
    #2;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_backpressure();
    test_same_cycle();
    test_back_to_back();
    test_saturation();
    test_reset_mid_txn();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
